serial_link_floo_chan_sched: RTL and testbench
==============================================

Name: serial_link_floo_chan_sched

Overview:
Credit-aware scheduler that shares one outbound AXIS serial-link stream between NumChan NoC flit channels, such as request and response.
- Grants a channel only if its flit is valid and the remote receiver has a free buffer slot for that channel, tracked as per-channel credits.
- Applies round-robin with a bounded burst length.
- Holds each grant (lock-in) until the downstream handshake completes.
- Sits between the NoC channel ports and the link's outbound AXIS FIFO. Replaces the credit-less round-robin arbiter there.

Parameters:
NumChan, 2, number of NoC channels sharing the link (>=2)
DataWidth, 64, flit payload width per channel
NumCredits, 8, receiver buffer depth per channel; initial credit count
MaxBurst, 4, max consecutive grants to one channel while another is eligible (1 = pure round-robin)
IdxWidth, max(1,$clog2(NumChan)), derived localparam
CntWidth, $clog2(NumCredits+1), derived localparam

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  allow new grants
chan_valid_i  in  NumChan  per-channel flit valid
chan_ready_o  out  NumChan  per-channel flit accepted
chan_data_i  in  NumChan*DataWidth  per-channel flit payload, channel c at [c*DataWidth +: DataWidth]
out_valid_o  out  1  outbound flit valid
out_ready_i  in  1  outbound flit accepted
out_data_o  out  DataWidth  selected payload
out_idx_o  out  IdxWidth  selected channel, used as link header
credit_ret_valid_i  in  1  remote freed one slot
credit_ret_idx_i  in  IdxWidth  channel of the returned credit
credits_o  out  NumChan*CntWidth  current credit count per channel
credit_err_o  out  1  sticky credit overflow flag

Behaviour:
- Reset values (asynchronous, applied immediately):
  - state IDLE; out_valid_o=0, chan_ready_o=0, out_idx_o=0, out_data_o=0.
  - credits=NumCredits per channel; credit_err_o=0.
  - last=NumChan-1, burst_cnt=0.
- Eligibility: channel c is eligible iff chan_valid_i[c] & credits[c]!=0.
- Selection, evaluated in IDLE with enable_i=1:
  - If last is eligible and burst_cnt<MaxBurst, select last.
  - Otherwise select the first eligible channel searching from (last+1) mod NumChan, with wrap-around.
  - If MaxBurst is reached but no other channel is eligible, select last and do not count this as a new burst; burst_cnt saturates at MaxBurst.
- State machine IDLE/LOCKED:
  - IDLE: if a selection exists, out_valid_o=1 in the same cycle (0-cycle latency). Handshake that cycle stays IDLE; otherwise go to LOCKED and register sel.
  - LOCKED: out_valid_o=1 and out_idx_o=sel are held. out_data_o=chan_data_i[sel]; the channel must hold its data stable per the AXI rule. Go to IDLE on handshake.
  - enable_i and eligibility of other channels are ignored while LOCKED.
  - enable_i=0 in IDLE: no grant.
- chan_ready_o[c]=out_ready_i & out_valid_o & (sel==c); all other bits are 0. No combinational path from chan_valid_i of unselected channels to their chan_ready_o.
- On handshake:
  - credits[sel] decrements by 1.
  - If sel==last, burst_cnt=min(burst_cnt+1,MaxBurst); else burst_cnt=1.
  - last=sel.
- Credit return:
  - credits[credit_ret_idx_i] increments by 1.
  - If a handshake on the same channel happens in the same cycle, the net change is 0 and the channel remains grantable.
  - Return to a channel already at NumCredits (with no same-cycle decrement): counter unchanged, credit_err_o set to 1 until reset.
  - credit_ret_idx_i>=NumChan: ignored and flags credit_err_o.
- Underflow is impossible because grants are gated by credits!=0. A credit of 0 takes effect from the cycle after the decrement.
- Assertion: out_valid_o & !out_ready_i |=> $stable(out_data_o) & $stable(out_idx_o) & out_valid_o.

Decomposition:
- noc_bridge_pkg: sched_state_e {IDLE, LOCKED}.
- Sub-module serial_link_credit_cnt: one per channel; inputs inc/dec; outputs count, nonzero, overflow.
- Arbitration and the FSM stay in the top module.

Test Plan:
1. NumCredits=8; ch0 valid for 10 beats, ready=1, no returns -> 8 handshakes idx=0, then out_valid_o=0, credits[0]=0; one return -> 9th beat next cycle.
2. ch0 and ch1 valid continuously, MaxBurst=4, credits replenished each beat -> out_idx_o = 0,0,0,0,1,1,1,1,0,...
3. ch1 granted, out_ready_i=0 for 5 cycles, ch0 raises valid at cycle 2 -> idx=1 and data stable for all 5 cycles; ch1 transfers, then ch0.
4. credits[1]=3, same-cycle handshake on ch1 and return to ch1 -> credits[1] stays 3; credit_err_o=0.
5. Return to ch0 at credits=8 -> credits[0]=8, credit_err_o=1 and stays 1 after further traffic.
6. rst_ni asserted mid-LOCKED -> out_valid_o=0 immediately; after release, both channels valid -> first grant to ch0, credits=8 each.

Source files
------------

// File: rtl/noc_bridge_pkg.sv
// Shared types for the serial-link NoC bridge: scheduler FSM encoding.
package noc_bridge_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

endpackage

// File: rtl/serial_link_credit_cnt.sv
// Per-channel credit counter: tracks free receiver slots for one channel.
module serial_link_credit_cnt #(
    parameter int unsigned NumCredits = 8,
    parameter int unsigned CntWidth   = $clog2(NumCredits + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                dec_i,
    output logic [CntWidth-1:0] count_o,
    output logic                nonzero_o,
    output logic                overflow_o
);

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(NumCredits);

    logic [CntWidth-1:0] count_q;

    // A return that would exceed the buffer depth is dropped and reported.
    assign overflow_o = inc_i & ~dec_i & (count_q == MaxCnt);
    assign nonzero_o  = (count_q != '0);
    assign count_o    = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= MaxCnt;
        end else if (inc_i && !dec_i && count_q != MaxCnt) begin
            count_q <= count_q + 1'b1;
        end else if (dec_i && !inc_i) begin
            count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/serial_link_floo_chan_sched.sv
// Credit-aware round-robin scheduler with bounded bursts that multiplexes
// NoC flit channels onto one outbound AXIS stream, holding grants until accepted.
module serial_link_floo_chan_sched
    import noc_bridge_pkg::*;
#(
    parameter int unsigned NumChan    = 2,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumCredits = 8,
    parameter int unsigned MaxBurst   = 4,
    localparam int unsigned IdxWidth  = (NumChan > 1) ? $clog2(NumChan) : 1,
    localparam int unsigned CntWidth  = $clog2(NumCredits + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          enable_i,
    input  logic [NumChan-1:0]            chan_valid_i,
    output logic [NumChan-1:0]            chan_ready_o,
    input  logic [NumChan*DataWidth-1:0]  chan_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [DataWidth-1:0]          out_data_o,
    output logic [IdxWidth-1:0]           out_idx_o,
    input  logic                          credit_ret_valid_i,
    input  logic [IdxWidth-1:0]           credit_ret_idx_i,
    output logic [NumChan*CntWidth-1:0]   credits_o,
    output logic                          credit_err_o,
    output logic                          state_o
);

    localparam int unsigned BurstWidth = $clog2(MaxBurst + 1);
    localparam logic [BurstWidth-1:0] BurstMax = BurstWidth'(MaxBurst);
    localparam logic [IdxWidth-1:0]   LastInit = IdxWidth'(NumChan - 1);

    sched_state_e state_q, state_d;
    logic [IdxWidth-1:0]   sel_q, sel_d;
    logic [IdxWidth-1:0]   last_q;
    logic [BurstWidth-1:0] burst_q;
    logic                  err_q;

    logic [NumChan-1:0] nonzero, ovf, inc, dec, elig;
    logic               pick_valid;
    logic [IdxWidth-1:0] pick_idx, cand;
    logic               grant_valid;
    logic [IdxWidth-1:0] grant_idx;
    logic               handshake;
    logic               ret_bad;

    assign elig = chan_valid_i & nonzero;

    // burst_q==0 only right after reset: no burst is running yet, so the
    // search starts at channel 0 instead of re-granting the reset "last".
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        if (burst_q != '0 && burst_q < BurstMax && elig[last_q]) begin
            pick_valid = 1'b1;
            pick_idx   = last_q;
        end else begin
            for (int i = 1; i <= int'(NumChan); i++) begin
                cand = IdxWidth'((int'(last_q) + i) % int'(NumChan));
                if (!pick_valid && elig[cand]) begin
                    pick_valid = 1'b1;
                    pick_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        grant_valid = 1'b0;
        grant_idx   = sel_q;
        case (state_q)
            IDLE: begin
                if (enable_i && pick_valid) begin
                    grant_valid = 1'b1;
                    grant_idx   = pick_idx;
                    if (!out_ready_i) begin
                        state_d = LOCKED;
                        sel_d   = pick_idx;
                    end
                end
            end
            LOCKED: begin
                grant_valid = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gating with rst_ni drops the grant the instant reset asserts.
    assign out_valid_o = grant_valid & rst_ni;
    assign out_idx_o   = out_valid_o ? grant_idx : '0;
    assign out_data_o  = out_valid_o ? chan_data_i[grant_idx*DataWidth +: DataWidth] : '0;
    assign handshake   = out_valid_o & out_ready_i;
    assign ret_bad     = credit_ret_valid_i & (32'(credit_ret_idx_i) >= NumChan);
    assign state_o     = state_q;

    always_comb begin
        chan_ready_o = '0;
        inc          = '0;
        for (int c = 0; c < int'(NumChan); c++) begin
            chan_ready_o[c] = handshake && (grant_idx == IdxWidth'(c));
            inc[c]          = credit_ret_valid_i && (credit_ret_idx_i == IdxWidth'(c));
        end
    end

    assign dec = chan_ready_o;

    for (genvar c = 0; c < NumChan; c++) begin : g_cnt
        serial_link_credit_cnt #(
            .NumCredits(NumCredits),
            .CntWidth  (CntWidth)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .inc_i     (inc[c]),
            .dec_i     (dec[c]),
            .count_o   (credits_o[c*CntWidth +: CntWidth]),
            .nonzero_o (nonzero[c]),
            .overflow_o(ovf[c])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            last_q  <= LastInit;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_q | (|ovf) | ret_bad;
            if (handshake) begin
                last_q <= grant_idx;
                if (grant_idx != last_q) begin
                    burst_q <= BurstWidth'(1);
                end else if (burst_q != BurstMax) begin
                    burst_q <= burst_q + 1'b1;
                end
            end
        end
    end

    assign credit_err_o = err_q;

    // Valid/ready: once offered, a flit and its index stay put until accepted.
    a_hold_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_valid_o && !out_ready_i |=> $stable(out_data_o) && $stable(out_idx_o) && out_valid_o);

endmodule

// File: tb/tb_serial_link_floo_chan_sched.sv
// Self-checking bench for serial_link_floo_chan_sched with a {idx,data} scoreboard.
module tb_serial_link_floo_chan_sched;

    localparam int NC = 2;
    localparam int DW = 64;
    localparam int IW = 1;
    localparam int CW = 4;

    logic           clk = 1'b0;
    logic           rst_ni;
    logic           enable;
    logic [NC-1:0]  chan_valid;
    logic [NC-1:0]  chan_ready;
    logic [DW-1:0]  data0, data1;
    logic [NC*DW-1:0] chan_data;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [IW-1:0]  out_idx;
    logic           ret_valid;
    logic [IW-1:0]  ret_idx;
    logic [NC*CW-1:0] credits;
    logic           credit_err;
    logic           state;

    int checks = 0;
    int failures = 0;
    logic [IW+DW-1:0] exp_q[$];
    logic [IW+DW-1:0] exp;

    assign chan_data = {data1, data0};

    always #5 clk = ~clk;

    serial_link_floo_chan_sched dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .enable_i          (enable),
        .chan_valid_i      (chan_valid),
        .chan_ready_o      (chan_ready),
        .chan_data_i       (chan_data),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_data_o        (out_data),
        .out_idx_o         (out_idx),
        .credit_ret_valid_i(ret_valid),
        .credit_ret_idx_i  (ret_idx),
        .credits_o         (credits),
        .credit_err_o      (credit_err),
        .state_o           (state)
    );

    function automatic logic [CW-1:0] credit(input int c);
        return credits[c*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        enable = 1'b0;
        chan_valid = '0;
        out_ready = 1'b0;
        ret_valid = 1'b0;
        ret_idx = '0;
        data0 = '0;
        data1 = '0;
        exp_q.delete();
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, chan_ready, out_idx, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%0b ready=%b idx=%0d data=%h, required all 0",
                     out_valid, chan_ready, out_idx, out_data);
        end
        checks++;
        if (credit(0) !== 4'd8 || credit(1) !== 4'd8 || credit_err !== 1'b0 || state !== 1'b0) begin
            failures++;
            $display("FAIL reset_credits: c0=%0d c1=%0d err=%0b state=%0b, required 8 8 0 0",
                     credit(0), credit(1), credit_err, state);
        end
        tick();
        enable = 1'b0;
        chan_valid = 2'b11;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || chan_ready !== 2'b00) begin
            failures++;
            $display("FAIL enable_low: valid=%0b ready=%b, required 0 00", out_valid, chan_ready);
        end
        tick();
        chan_valid = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_credit_exhaust();
        int hs;
        logic did;
        apply_reset();
        enable = 1'b1;
        chan_valid = 2'b01;
        out_ready = 1'b1;
        data0 = 64'hA000;
        for (int n = 0; n < 8; n++) exp_q.push_back({1'b0, 64'hA000 + 64'(n)});
        hs = 0;
        for (int beat = 0; beat < 10; beat++) begin
            @(negedge clk);
            did = out_valid & out_ready;
            if (did) begin
                hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL exhaust_extra: unexpected grant idx=%0d at beat %0d", out_idx, beat);
                end else begin
                    exp = exp_q.pop_front();
                    if ({out_idx, out_data} !== exp) begin
                        failures++;
                        $display("FAIL exhaust_beat: got idx=%0d data=%h, required idx=%0d data=%h",
                                 out_idx, out_data, exp[DW], exp[DW-1:0]);
                    end
                end
            end
            tick();
            if (did) data0 = data0 + 1;
        end
        @(negedge clk);
        checks++;
        if (hs !== 8 || out_valid !== 1'b0 || credit(0) !== 4'd0 || credit(1) !== 4'd8) begin
            failures++;
            $display("FAIL exhaust_stop: hs=%0d valid=%0b c0=%0d c1=%0d, required 8 0 0 8",
                     hs, out_valid, credit(0), credit(1));
        end
        tick();
        ret_valid = 1'b1;
        ret_idx = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL exhaust_ret_cycle: valid=%0b, required 0", out_valid);
        end
        exp_q.push_back({1'b0, data0});
        tick();
        ret_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            failures++;
            $display("FAIL exhaust_ninth: valid=%0b, required 1", out_valid);
        end else begin
            exp = exp_q.pop_front();
            if ({out_idx, out_data} !== exp) begin
                failures++;
                $display("FAIL exhaust_ninth: got idx=%0d data=%h, required idx=%0d data=%h",
                         out_idx, out_data, exp[DW], exp[DW-1:0]);
            end
        end
        tick();
        chan_valid = '0;
        @(negedge clk);
        checks++;
        if (credit(0) !== 4'd0) begin
            failures++;
            $display("FAIL exhaust_final_credit: c0=%0d, required 0", credit(0));
        end
        tick();
    endtask

    task automatic test_burst();
        logic [DW-1:0] m0, m1;
        logic pidx;
        apply_reset();
        enable = 1'b1;
        chan_valid = 2'b11;
        out_ready = 1'b1;
        data0 = 64'hB000;
        data1 = 64'hC000;
        m0 = data0;
        m1 = data1;
        for (int k = 0; k < 12; k++) begin
            if (((k / 4) % 2) == 0) begin
                exp_q.push_back({1'b0, m0});
                m0 = m0 + 1;
            end else begin
                exp_q.push_back({1'b1, m1});
                m1 = m1 + 1;
            end
        end
        for (int k = 0; k < 12; k++) begin
            ret_valid = 1'b1;
            ret_idx = exp_q[0][DW];
            @(negedge clk);
            exp = exp_q.pop_front();
            pidx = exp[DW];
            checks++;
            if (!(out_valid && out_ready) || {out_idx, out_data} !== exp) begin
                failures++;
                $display("FAIL burst_beat%0d: valid=%0b idx=%0d data=%h, required idx=%0d data=%h",
                         k, out_valid, out_idx, out_data, exp[DW], exp[DW-1:0]);
            end
            tick();
            if (pidx) data1 = data1 + 1;
            else data0 = data0 + 1;
        end
        ret_valid = 1'b0;
        chan_valid = '0;
        @(negedge clk);
        checks++;
        if (credit(0) !== 4'd8 || credit(1) !== 4'd8) begin
            failures++;
            $display("FAIL burst_credits: c0=%0d c1=%0d, required 8 8", credit(0), credit(1));
        end
        tick();
    endtask

    task automatic test_stall();
        apply_reset();
        enable = 1'b1;
        chan_valid = 2'b10;
        out_ready = 1'b0;
        data1 = 64'hD111;
        data0 = 64'hE000;
        exp_q.push_back({1'b1, 64'hD111});
        exp_q.push_back({1'b0, 64'hE000});
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (cyc == 2) chan_valid = 2'b11;
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 1'b1 || out_data !== 64'hD111 || chan_ready !== 2'b00) begin
                failures++;
                $display("FAIL stall_hold%0d: valid=%0b idx=%0d data=%h ready=%b, required 1 1 d111 00",
                         cyc, out_valid, out_idx, out_data, chan_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (chan_ready !== 2'b10 || {out_idx, out_data} !== exp) begin
            failures++;
            $display("FAIL stall_release: ready=%b idx=%0d data=%h, required 10 idx=%0d data=%h",
                     chan_ready, out_idx, out_data, exp[DW], exp[DW-1:0]);
        end
        tick();
        chan_valid = 2'b01;
        @(negedge clk);
        exp = exp_q.pop_front();
        checks++;
        if (chan_ready !== 2'b01 || {out_idx, out_data} !== exp) begin
            failures++;
            $display("FAIL stall_next: ready=%b idx=%0d data=%h, required 01 idx=%0d data=%h",
                     chan_ready, out_idx, out_data, exp[DW], exp[DW-1:0]);
        end
        tick();
        chan_valid = '0;
        out_ready = 1'b0;
    endtask

    task automatic test_same_cycle();
        apply_reset();
        enable = 1'b1;
        chan_valid = 2'b10;
        out_ready = 1'b1;
        data1 = 64'hF000;
        for (int n = 0; n < 5; n++) tick();
        chan_valid = '0;
        @(negedge clk);
        checks++;
        if (credit(1) !== 4'd3) begin
            failures++;
            $display("FAIL same_cycle_pre: c1=%0d, required 3", credit(1));
        end
        tick();
        chan_valid = 2'b10;
        ret_valid = 1'b1;
        ret_idx = 1'b1;
        @(negedge clk);
        checks++;
        if (chan_ready !== 2'b10) begin
            failures++;
            $display("FAIL same_cycle_hs: ready=%b, required 10", chan_ready);
        end
        tick();
        chan_valid = '0;
        ret_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (credit(1) !== 4'd3 || credit_err !== 1'b0) begin
            failures++;
            $display("FAIL same_cycle_post: c1=%0d err=%0b, required 3 0", credit(1), credit_err);
        end
        tick();
    endtask

    task automatic test_overflow();
        apply_reset();
        ret_valid = 1'b1;
        ret_idx = 1'b0;
        tick();
        ret_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (credit(0) !== 4'd8 || credit_err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_flag: c0=%0d err=%0b, required 8 1", credit(0), credit_err);
        end
        tick();
        enable = 1'b1;
        chan_valid = 2'b01;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) tick();
        chan_valid = '0;
        ret_valid = 1'b1;
        ret_idx = 1'b0;
        tick();
        ret_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (credit(0) !== 4'd6 || credit_err !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky: c0=%0d err=%0b, required 6 1", credit(0), credit_err);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_locked();
        apply_reset();
        enable = 1'b1;
        chan_valid = 2'b10;
        out_ready = 1'b0;
        data1 = 64'h5151;
        tick();
        @(negedge clk);
        checks++;
        if (state !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL locked_entry: state=%0b valid=%0b, required 1 1", state, out_valid);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({out_valid, chan_ready, out_idx, out_data, state} !== '0) begin
            failures++;
            $display("FAIL async_reset: valid=%0b ready=%b idx=%0d data=%h state=%0b, required all 0",
                     out_valid, chan_ready, out_idx, out_data, state);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        chan_valid = 2'b11;
        out_ready = 1'b1;
        data0 = 64'h6060;
        @(negedge clk);
        checks++;
        if (credit(0) !== 4'd8 || credit(1) !== 4'd8 || out_valid !== 1'b1 ||
            out_idx !== 1'b0 || out_data !== 64'h6060 || chan_ready !== 2'b01) begin
            failures++;
            $display("FAIL post_reset_grant: c0=%0d c1=%0d valid=%0b idx=%0d data=%h ready=%b, required 8 8 1 0 6060 01",
                     credit(0), credit(1), out_valid, out_idx, out_data, chan_ready);
        end
        tick();
        chan_valid = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_credit_exhaust();
        test_burst();
        test_stall();
        test_same_cycle();
        test_overflow();
        test_reset_locked();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
